// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the sequential ALU.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'd0;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd4;
  localparam logic [OP_W-1:0] OP_MOD  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// quotient/remainder show the post-iteration values so the final step can be captured on the edge it completes.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // Extra top bit keeps the compare exact before the subtract brings it back in range.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_div;
  assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_div <= divisor;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_quo <= w_quo_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign quotient  = w_quo_next;
  assign remainder = w_rem_next;
  assign valid     = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered ALU between accumulator and data bus: single-cycle pass/add/sub/mul,
// multi-cycle div/mod through seq_divider, with busy/done handshake and result flags.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  operation,
  input  logic [WIDTH-1:0] in_bus,
  input  logic [WIDTH-1:0] in_AC,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_is_mod;
  logic             w_load;
  logic             w_upd;
  logic             w_dbz;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_mul;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_div_valid;

  assign w_mul = in_AC * in_bus;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .dividend  (in_AC),
    .divisor   (in_bus),
    .quotient  (w_quo),
    .remainder (w_rem),
    .valid     (w_div_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_upd        = 1'b0;
    w_dbz        = 1'b0;
    w_result     = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_upd        = 1'b1;
          w_state_next = DONE;
          case (operation)
            OP_MUL: w_result = w_mul;
            OP_ADD: w_result = in_AC + in_bus;
            OP_SUB: w_result = in_AC - in_bus;
            OP_DIV, OP_MOD: begin
              if (in_bus == '0) begin
                w_result = (operation == OP_MOD) ? in_AC : '1;
                w_dbz    = 1'b1;
              end else begin
                w_upd        = 1'b0;
                w_load       = 1'b1;
                w_state_next = DIV;
              end
            end
            default: w_result = in_bus;
          endcase
        end
      end
      DIV: begin
        if (w_div_valid) begin
          w_result     = r_is_mod ? w_rem : w_quo;
          w_upd        = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_mod    <= 1'b0;
      data_out    <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_is_mod <= (operation == OP_MOD);
      end
      if (w_upd) begin
        data_out    <= w_result;
        zero        <= (w_result == '0);
        div_by_zero <= w_dbz;
      end
    end
  end

  assign busy = (r_state == DIV);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=16.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  operation;
  logic [15:0] in_bus;
  logic [15:0] in_AC;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic        zero;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .operation   (operation),
    .in_bus      (in_bus),
    .in_AC       (in_AC),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one start and returns in the first cycle done is high (or after a bound).
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int nbusy);
    @(negedge clk);
    operation = op;
    in_AC     = a;
    in_bus    = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat, input int exp_busy,
                          input logic [15:0] exp_data, input logic exp_zero, input logic exp_dbz);
    int lat;
    int nbusy;
    do_op(op, a, b, lat, nbusy);
    $display("op %0d A=%0h B=%0h -> data_out=%0h zero=%0b dbz=%0b latency=%0d busy_cycles=%0d",
             op, a, b, data_out, zero, div_by_zero, lat, nbusy);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
    chk({tag, ".zero"}, 32'(zero), 32'(exp_zero));
    chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    int nbusy;
    logic [15:0] res;

    rst       = 1'b1;
    start     = 1'b0;
    operation = 3'd0;
    in_bus    = '0;
    in_AC     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.data_out", 32'(data_out), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.zero", 32'(zero), 32'd0);
    chk("reset.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op_check("add", 3'd2, 16'd7, 16'd5, 1, 0, 16'd12, 1'b0, 1'b0);
    op_check("sub_wrap", 3'd3, 16'd3, 16'd5, 1, 0, 16'hFFFE, 1'b0, 1'b0);
    op_check("mul_trunc", 3'd1, 16'h0100, 16'h0100, 1, 0, 16'h0000, 1'b1, 1'b0);
    op_check("add_wrap", 3'd2, 16'hFFFF, 16'd1, 1, 0, 16'h0000, 1'b1, 1'b0);
    op_check("mul", 3'd1, 16'd300, 16'd7, 1, 0, 16'd2100, 1'b0, 1'b0);
    op_check("reserved6", 3'd6, 16'd9, 16'h1234, 1, 0, 16'h1234, 1'b0, 1'b0);
    op_check("div", 3'd4, 16'd100, 16'd7, 17, 16, 16'd14, 1'b0, 1'b0);
    op_check("mod", 3'd5, 16'd100, 16'd7, 17, 16, 16'd2, 1'b0, 1'b0);
    op_check("div_max", 3'd4, 16'hFFFF, 16'd1, 17, 16, 16'hFFFF, 1'b0, 1'b0);
    op_check("mod_zero", 3'd5, 16'hFFFF, 16'h00FF, 17, 16, 16'h0000, 1'b1, 1'b0);
    op_check("div_big", 3'd4, 16'hFFFF, 16'hFFFE, 17, 16, 16'd1, 1'b0, 1'b0);
    op_check("div_by0", 3'd4, 16'd9, 16'd0, 1, 0, 16'hFFFF, 1'b0, 1'b1);
    op_check("mod_by0", 3'd5, 16'd9, 16'd0, 1, 0, 16'd9, 1'b0, 1'b1);
    op_check("pass", 3'd0, 16'd0, 16'd3, 1, 0, 16'd3, 1'b0, 1'b0);

    // start during DONE must be ignored
    do_op(3'd2, 16'd2, 16'd2, lat, nbusy);
    chk("done_ign.latency", 32'(lat), 32'd1);
    operation = 3'd0;
    in_bus    = 16'd77;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    $display("start in DONE: data_out=%0h extra_done=%0d", data_out, ndone);
    chk("done_ign.data_out", 32'(data_out), 32'd4);
    chk("done_ign.extra_done", 32'(ndone), 32'd0);

    // make data_out nonzero, then reset mid-divide
    op_check("pre_rst", 3'd0, 16'd0, 16'd3, 1, 0, 16'd3, 1'b0, 1'b0);
    @(negedge clk);
    operation = 3'd4;
    in_AC     = 16'd1000;
    in_bus    = 16'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    repeat (7) begin
      if (done === 1'b1) ndone++;
      @(posedge clk);
      #1;
    end
    chk("mid_div.busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset mid-divide: data_out=%0h busy=%0b done=%0b", data_out, busy, done);
    chk("rst_async.data_out", 32'(data_out), 32'd0);
    chk("rst_async.busy", 32'(busy), 32'd0);
    chk("rst_async.done", 32'(done), 32'd0);
    chk("rst_async.zero", 32'(zero), 32'd0);
    chk("rst_async.dbz", 32'(div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("rst_async.no_done", 32'(ndone), 32'd0);
    op_check("post_rst", 3'd2, 16'd1, 16'd1, 1, 0, 16'd2, 1'b0, 1'b0);

    // start and operand changes during DIV are ignored
    @(negedge clk);
    operation = 3'd4;
    in_AC     = 16'd50;
    in_bus    = 16'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    res   = '0;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) begin
        start     = 1'b1;
        operation = 3'd2;
        in_AC     = 16'd1;
        in_bus    = 16'd1;
      end
      if (c == 4) begin
        start  = 1'b0;
        in_AC  = 16'd77;
        in_bus = 16'd0;
      end
      if (done === 1'b1) begin
        ndone++;
        res = data_out;
      end
      @(posedge clk);
      #1;
    end
    $display("start during DIV: data_out=%0h done_pulses=%0d", res, ndone);
    chk("div_ign.data_out", 32'(res), 32'd10);
    chk("div_ign.done_pulses", 32'(ndone), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered successor to the datapath's combinational ALU.
- Single-cycle pass/add/sub/mul.
- Iterative restoring divider for integer divide and modulo, with a start/busy/done handshake.
- Registered zero and divide-by-zero flags.
- Sits between the accumulator (AC) and the shared data bus. The core control unit stalls on busy.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
operation  input  3  opcode, latched at accepted start
in_bus  input  WIDTH  operand B (bus), latched at accepted start
in_AC  input  WIDTH  operand A (accumulator), latched at accepted start
data_out  output  WIDTH  registered result; holds until next done
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when data_out/flags update
zero  output  1  data_out == 0, updated with done
div_by_zero  output  1  last div/mod had B == 0, updated with done

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset (asynchronous, any state, including mid-divide):
  - state = IDLE; data_out, busy, done, zero, div_by_zero = 0.
  - Internal operand/quotient/remainder registers = 0.
  - An in-flight operation is discarded with no done pulse.
- Opcodes: 0 pass (B), 1 mul, 2 add, 3 sub, 4 div (A/B), 5 mod (A%B). 6 and 7 are reserved and behave as pass.
- Arithmetic is unsigned, result truncated to WIDTH bits:
  - add/sub wrap modulo 2^WIDTH; no carry/borrow output.
  - mul keeps the low WIDTH bits of the 2*WIDTH product.
- States: IDLE, DIV, DONE.
- IDLE + start with op in {0,1,2,3,6,7}:
  - Result computed from live inputs and registered on the same edge.
  - Next state DONE; done = 1 in the following cycle (latency 1). busy stays 0.
- IDLE + start with op in {4,5}, B != 0:
  - Latch A and B; load remainder = 0, iteration counter = WIDTH.
  - Next state DIV; busy = 1.
- DIV, one iteration per cycle (restoring, MSB first):
  - Shift {rem, quo} left by 1, bringing in the next dividend bit.
  - If rem >= B: subtract B and set the quotient bit.
  - After WIDTH iterations: data_out = quotient (op 4) or remainder (op 5); next DONE.
  - Latency from the start edge to done high = WIDTH+1 cycles. busy drops in the same cycle done rises.
- IDLE + start with op in {4,5}, B == 0:
  - No iteration. data_out = all-ones (div) or A (mod); div_by_zero = 1.
  - Next DONE, latency 1.
- DONE: done = 1 for exactly one cycle, then IDLE.
  - start asserted during DONE is ignored. Back-to-back throughput is one result per 2 cycles for single-cycle ops.
- start while busy (DIV) is ignored. Operands and operation changing during DIV have no effect.
- zero and div_by_zero update only with done. div_by_zero is cleared by any completed non-faulting operation.
- Minimum legal case: WIDTH=2. The counter width is clog2(WIDTH+1).

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_PASS..OP_MOD.
  - State encoding IDLE/DIV/DONE.
  - Opcode width constant (3).
- One sub-module: seq_divider (WIDTH param; ports clk, rst, load, dividend, divisor, quotient, remainder, valid).
  - seq_alu owns the FSM, the single-cycle ops and the flags.

Test Plan:
- WIDTH=16, start op=2 A=7 B=5 -> next cycle done=1, data_out=12, zero=0, busy never high.
- op=3 A=3 B=5 -> data_out=0xFFFE. Then op=1 A=0x0100 B=0x0100 -> data_out=0x0000, zero=1.
- op=4 A=100 B=7 -> busy for 16 cycles, done on cycle 17, data_out=14. op=5 same operands -> data_out=2, div_by_zero=0.
- op=4 A=9 B=0 -> done after 1 cycle, data_out=0xFFFF, div_by_zero=1. Then op=5 A=9 B=0 -> data_out=9. Then op=0 B=3 -> div_by_zero=0.
- Start op=4 A=1000 B=3; assert rst at cycle 8 -> all outputs 0 immediately, no done. After release, op=2 A=1 B=1 -> data_out=2.
- During DIV (A=50 B=5), pulse start with op=2 and change A/B -> ignored; final data_out=10, exactly one done pulse.
